// File: rtl/fmul.sv
// fmul: iterative AVR FMUL (1.7 x 1.7 -> 1.15) over 8 cycles with start/busy/done handshake.
// Define FMUL_SIGNED_EN to add i_mode and the FMULS / FMULSU variants.
module fmul (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_rd,
  input  logic [7:0] i_rr,
`ifdef FMUL_SIGNED_EN
  input  logic [1:0] i_mode,
`endif
  output logic [7:0] o_r1,
  output logic [7:0] o_r0,
  output logic       o_c,
  output logic       o_z,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [15:0] md_reg;
  logic [7:0]  mr_reg;
  logic [15:0] acc_reg;
  logic        rr_signed_reg;
  logic [7:0]  r1_reg, r0_reg;
  logic        c_reg, z_reg;

  logic        accept;
  logic        rd_signed, rr_signed;
  logic        last_iter;
  logic [15:0] term;
  logic [15:0] sum;

  assign accept = i_start && (state_reg != RUN);

`ifdef FMUL_SIGNED_EN
  always_comb begin
    rd_signed = 1'b0;
    rr_signed = 1'b0;
    case (i_mode)
      2'b01: begin
        rd_signed = 1'b1;
        rr_signed = 1'b1;
      end
      2'b10: rd_signed = 1'b1;
      default: begin
        rd_signed = 1'b0;
        rr_signed = 1'b0;
      end
    endcase
  end
`else
  assign rd_signed = 1'b0;
  assign rr_signed = 1'b0;
`endif

  // Multiplier bit 7 carries weight -128 when Rr is signed, so the last partial product is subtracted.
  assign last_iter = (cnt_reg == 3'd7);
  assign term      = mr_reg[0] ? md_reg : 16'h0000;
  assign sum       = (last_iter && rr_signed_reg) ? (acc_reg - term) : (acc_reg + term);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = i_start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      md_reg        <= 16'h0000;
      mr_reg        <= 8'h00;
      acc_reg       <= 16'h0000;
      rr_signed_reg <= 1'b0;
      r1_reg        <= 8'h00;
      r0_reg        <= 8'h00;
      c_reg         <= 1'b0;
      z_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        md_reg        <= rd_signed ? {{8{i_rd[7]}}, i_rd} : {8'h00, i_rd};
        mr_reg        <= i_rr;
        acc_reg       <= 16'h0000;
        cnt_reg       <= 3'd0;
        rr_signed_reg <= rr_signed;
      end else if (state_reg == RUN) begin
        acc_reg <= sum;
        md_reg  <= {md_reg[14:0], 1'b0};
        mr_reg  <= {1'b0, mr_reg[7:1]};
        cnt_reg <= cnt_reg + 3'd1;
        if (last_iter) begin
          // Result is the product shifted left by one; the bit shifted out becomes C.
          r1_reg <= sum[14:7];
          r0_reg <= {sum[6:0], 1'b0};
          c_reg  <= sum[15];
          z_reg  <= (sum[14:0] == 15'h0000);
        end
      end
    end
  end

  assign o_r1   = r1_reg;
  assign o_r0   = r0_reg;
  assign o_c    = c_reg;
  assign o_z    = z_reg;
  assign o_busy = (state_reg == RUN);
  assign o_done = (state_reg == DONE);

endmodule

// File: tb/tb_fmul.sv
// tb_fmul: directed + random scoreboard bench for fmul (handshake, reset abort, optional signed modes).
module tb_fmul;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] rd, rr;
  logic [1:0] mode;
  logic [7:0] o_r1, o_r0;
  logic       o_c, o_z, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  rd;
    logic [7:0]  rr;
    logic [1:0]  mode;
    logic [17:0] exp;
  } txn_t;

  txn_t q[$];

  fmul dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_rd    (rd),
    .i_rr    (rr),
`ifdef FMUL_SIGNED_EN
    .i_mode  (mode),
`endif
    .o_r1    (o_r1),
    .o_r0    (o_r0),
    .o_c     (o_c),
    .o_z     (o_z),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer product with the operand signedness chosen by mode.
  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int x, y, p;
    logic [15:0] pp, sh;
    x = int'(a);
    y = int'(b);
    if ((m == 2'b01 || m == 2'b10) && a[7]) x = x - 256;
    if (m == 2'b01 && b[7]) y = y - 256;
    p  = x * y;
    pp = p[15:0];
    sh = {pp[14:0], 1'b0};
    return {sh, pp[15], (sh == 16'h0000)};
  endfunction

  // Drive a request (caller is just past a negedge with the DUT free) and record its expected result.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    txn_t t;
    rd = a; rr = b; mode = m; start = 1'b1;
    @(posedge clk);
    t.rd = a; t.rr = b; t.mode = m; t.exp = model(a, b, m);
    q.push_back(t);
    #1;
    start = 1'b0;
    rd = 8'($urandom);
    rr = 8'($urandom);
  endtask

  // Wait for o_done; optionally pulse an ignored start at negedge pulse_at while busy.
  task automatic wait_done(input string tag, input int pulse_at, input logic [17:0] hold_exp);
    int k;
    logic busy_ok;
    busy_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_done) break;
      if (!o_busy) busy_ok = 1'b0;
      if (pulse_at != 0 && k == pulse_at) begin
        check({tag, "_hold"}, {14'h0, o_r1, o_r0, o_c, o_z}, {14'h0, hold_exp});
        rd = 8'hFF; rr = 8'hFF; start = 1'b1;
      end
      if (pulse_at != 0 && k == pulse_at + 1) start = 1'b0;
    end
    check({tag, "_latency"}, k, 9);
    check({tag, "_busy_during_run"}, {31'h0, busy_ok}, 32'h1);
  endtask

  task automatic run_const(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           input logic [7:0] er1, input logic [7:0] er0, input logic ec, input logic ez);
    logic [17:0] prev;
    prev = {o_r1, o_r0, o_c, o_z};
    start_op(a, b, m);
    wait_done(tag, 0, prev);
    check({tag, "_r1"}, {24'h0, o_r1}, {24'h0, er1});
    check({tag, "_r0"}, {24'h0, o_r0}, {24'h0, er0});
    check({tag, "_c"}, {31'h0, o_c}, {31'h0, ec});
    check({tag, "_z"}, {31'h0, o_z}, {31'h0, ez});
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      check("busy_low_in_done", {31'h0, o_busy}, 32'h0);
      if (q.size() == 0) begin
        check("done_without_accept", 32'h1, 32'h0);
      end else begin
        txn_t t;
        t = q.pop_front();
        check("result", {14'h0, o_r1, o_r0, o_c, o_z}, {14'h0, t.exp});
        $display("txn rd=%h rr=%h mode=%0d -> r1=%h r0=%h c=%b z=%b (exp %h)",
                 t.rd, t.rr, t.mode, o_r1, o_r0, o_c, o_z, t.exp);
      end
    end
  end

  initial begin
    logic [17:0] held;
    logic        done_seen;
    rst_n = 1'b0; start = 1'b0; rd = 8'h00; rr = 8'h00; mode = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'h0, o_r1, o_r0, o_c, o_z, o_busy, o_done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_const("p80x80", 8'h80, 8'h80, 2'b00, 8'h80, 8'h00, 1'b0, 1'b0);
    run_const("p80x00", 8'h80, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    run_const("p40x40", 8'h40, 8'h40, 2'b00, 8'h20, 8'h00, 1'b0, 1'b0);
    run_const("p01x01", 8'h01, 8'h01, 2'b00, 8'h00, 8'h02, 1'b0, 1'b0);
    run_const("p40xC0", 8'h40, 8'hC0, 2'b00, 8'h60, 8'h00, 1'b0, 1'b0);
    run_const("pFFxFF", 8'hFF, 8'hFF, 2'b00, 8'hFC, 8'h02, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      held = {o_r1, o_r0, o_c, o_z};
      start_op(8'($urandom), 8'($urandom), 2'b00);
      wait_done("random", 0, held);
    end

    // Restart while busy is ignored; outputs hold the previous result meanwhile.
    held = {o_r1, o_r0, o_c, o_z};
    start_op(8'h40, 8'h40, 2'b00);
    wait_done("ignore_busy", 3, held);
    check("ignore_busy_r1", {24'h0, o_r1}, 32'h20);

    // Back-to-back: request during the done cycle.
    start_op(8'h03, 8'h05, 2'b00);
    wait_done("b2b_first", 0, 18'h0);
    start_op(8'hFF, 8'hFF, 2'b00);
    wait_done("b2b_second", 0, 18'h0);
    check("b2b_r1", {24'h0, o_r1}, 32'hFC);

    // Asynchronous reset in the middle of RUN aborts with no done pulse.
    start_op(8'hC3, 8'h7E, 2'b00);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("abort_outputs", {26'h0, o_r1, o_r0, o_c, o_z, o_busy, o_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_done || o_busy) done_seen = 1'b1;
    end
    check("abort_no_done", {31'h0, done_seen}, 32'h0);

`ifdef FMUL_SIGNED_EN
    run_const("s80x80", 8'h80, 8'h80, 2'b01, 8'h80, 8'h00, 1'b0, 1'b0);
    run_const("sC0x40", 8'hC0, 8'h40, 2'b01, 8'hE0, 8'h00, 1'b1, 1'b0);
    run_const("suFFxFF", 8'hFF, 8'hFF, 2'b10, 8'hFE, 8'h02, 1'b1, 1'b0);
    run_const("m11FFxFF", 8'hFF, 8'hFF, 2'b11, 8'hFC, 8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      held = {o_r1, o_r0, o_c, o_z};
      start_op(8'($urandom), 8'($urandom), 2'($urandom));
      wait_done("random_signed", 0, held);
    end
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
